// File: rtl/serial_subtractor.sv
// Bit-serial a - b: one difference bit per clock, LSB first, with valid/ready
// handshakes on both sides and borrow/overflow flags on the finished result.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_acc;
  logic             r_br;

  logic             w_accept;
  logic             w_last;
  logic             w_d_bit;
  logic             w_br_next;
  logic [WIDTH-1:0] w_acc_full;

  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_last     = (r_state == S_RUN) && (r_cnt == LAST_BIT);
  assign w_d_bit    = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  // New bit enters at the top; after WIDTH shifts bit 0 holds the first result bit.
  assign w_acc_full = {w_d_bit, r_acc};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
      d     <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_acc <= w_acc_full[WIDTH-1:1];
      r_br  <= w_br_next;
      r_cnt <= r_cnt + CW'(1);
      // Outputs change only when the whole result is ready; on this edge r_a[0]/r_b[0] are the sign bits.
      if (w_last) begin
        d    <= w_acc_full;
        bout <= w_br_next;
        ovf  <= (r_a[0] != r_b[0]) && (w_d_bit != r_a[0]);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (WIDTH=8), plus hand
// sequences for reset, backpressure, mid-run reset and back-to-back operation.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;

  int n_pass;
  int n_total;
  int cyc;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
  } vec_t;

  vec_t vecs[10];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for out_valid; lat counts edges since the caller's last tick (the accept edge).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // One full operation with out_ready held high; operands are scrambled right after accept.
  task automatic do_op(input vec_t v, input string tag);
    int lat;
    chk({tag, " in_ready pre"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a         = v.a;
    b         = v.b;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    chk({tag, " in_ready run"}, 32'(in_ready), 32'd0);
    wait_valid(lat);
    chk({tag, " latency"}, 32'(lat), 32'd8);
    $display("op %s: a=0x%02h b=0x%02h -> d=0x%02h bout=%0b ovf=%0b (exp 0x%02h %0b %0b)",
             tag, v.a, v.b, d, bout, ovf, v.d, v.bout, v.ovf);
    chk({tag, " d"},    32'(d),    32'(v.d));
    chk({tag, " bout"}, 32'(bout), 32'(v.bout));
    chk({tag, " ovf"},  32'(ovf),  32'(v.ovf));
    tick();
    chk({tag, " in_ready post"},  32'(in_ready),  32'd1);
    chk({tag, " out_valid post"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int   lat;
    int   prev_acc;
    int   acc;
    vec_t v;

    n_pass  = 0;
    n_total = 0;

    vecs[0] = '{8'h0A, 8'h05, 8'h05, 1'b0, 1'b0};
    vecs[1] = '{8'h05, 8'h0A, 8'hFB, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[4] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
    vecs[5] = '{8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h93, 8'h00, 8'h93, 1'b0, 1'b0};
    vecs[7] = '{8'hC8, 8'h64, 8'h64, 1'b0, 1'b1};
    vecs[8] = '{8'h01, 8'h02, 8'hFF, 1'b1, 1'b0};
    vecs[9] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};

    // Reset held with in_valid=1 must not accept.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    a         = 8'h33;
    b         = 8'h11;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst in_ready",  32'(in_ready),  32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst d",         32'(d),         32'd0);
    chk("rst bout",      32'(bout),      32'd0);
    chk("rst ovf",       32'(ovf),       32'd0);

    // First accept happens on the first edge with rst_n=1.
    rst_n = 1'b1;
    v = '{8'h33, 8'h11, 8'h22, 1'b0, 1'b0};
    do_op(v, "post_reset");

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result held 5 cycles in DONE.
    in_valid  = 1'b1;
    a         = 8'hC8;
    b         = 8'h64;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    a = 8'h00;
    b = 8'h00;
    wait_valid(lat);
    chk("bp latency", 32'(lat), 32'd8);
    for (int k = 0; k < 5; k++) begin
      $display("bp cycle %0d: out_valid=%0b in_ready=%0b d=0x%02h bout=%0b ovf=%0b",
               k, out_valid, in_ready, d, bout, ovf);
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp in_ready",  32'(in_ready),  32'd0);
      chk("bp d",         32'(d),         32'h64);
      chk("bp bout",      32'(bout),      32'd0);
      chk("bp ovf",       32'(ovf),       32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp release in_ready",  32'(in_ready),  32'd1);
    chk("bp release out_valid", 32'(out_valid), 32'd0);

    // Reset asserted on the 4th RUN edge.
    in_valid = 1'b1;
    a        = 8'hFF;
    b        = 8'h01;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    $display("mid-run reset: out_valid=%0b in_ready=%0b d=0x%02h", out_valid, in_ready, d);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst d",         32'(d),         32'd0);
    chk("midrst in_ready",  32'(in_ready),  32'd1);
    v = '{8'h03, 8'h01, 8'h02, 1'b0, 1'b0};
    do_op(v, "after_midrst");

    // Back-to-back with in_valid held high; operands change right after each accept.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = vecs[1].a;
    b         = vecs[1].b;
    prev_acc  = 0;
    for (int k = 0; k < 4; k++) begin
      chk("b2b in_ready", 32'(in_ready), 32'd1);
      tick();
      acc = cyc;
      if (k > 0) chk("b2b spacing", 32'(acc - prev_acc), 32'd10);
      prev_acc = acc;
      if (k < 3) begin
        a = vecs[k + 2].a;
        b = vecs[k + 2].b;
      end else begin
        in_valid = 1'b0;
      end
      wait_valid(lat);
      $display("b2b %0d: accept cycle %0d d=0x%02h bout=%0b ovf=%0b (exp 0x%02h %0b %0b)",
               k, acc, d, bout, ovf, vecs[k + 1].d, vecs[k + 1].bout, vecs[k + 1].ovf);
      chk("b2b latency", 32'(lat),  32'd8);
      chk("b2b d",       32'(d),    32'(vecs[k + 1].d));
      chk("b2b bout",    32'(bout), 32'(vecs[k + 1].bout));
      chk("b2b ovf",     32'(ovf),  32'(vecs[k + 1].ovf));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  input  1  operands a/b presented.
REQ-005 Port: in_ready  output  1  block accepts operands this cycle.
REQ-006 Port: a  input  WIDTH  minuend, unsigned or two's complement.
REQ-007 Port: b  input  WIDTH  subtrahend, unsigned or two's complement.
REQ-008 Port: out_valid  output  1  result d/bout/ovf valid.
REQ-009 Port: out_ready  input  1  consumer takes result this cycle.
REQ-010 Port: d  output  WIDTH  difference a - b, modulo 2^WIDTH.
REQ-011 Port: bout  output  1  borrow out; 1 iff unsigned a < unsigned b.
REQ-012 Port: ovf  output  1  signed overflow of a - b.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN, DONE, computing one result bit per clock, LSB first.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept: on an edge with state IDLE and in_valid=1, the block SHALL latch a and b, clear borrow and bit counter, enter RUN.
REQ-016 a and b SHALL be sampled only at the accept edge; later changes SHALL have no effect on the result.
REQ-017 in_valid while not in IDLE SHALL be ignored (no operand loss claimed; producer holds per valid/ready rule).
REQ-018 Each RUN edge for bit i: d[i] = a[i] ^ b[i] ^ br; br_next = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br).
REQ-019 After exactly WIDTH RUN edges the block SHALL enter DONE; out_valid SHALL first be visible WIDTH edges after the accept edge.
REQ-020 In DONE: bout = final borrow; ovf = (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]).
REQ-021 d, bout, ovf SHALL remain stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-022 On an edge with out_valid=1 and out_ready=1 the block SHALL return to IDLE; in_ready=1 the following cycle.
REQ-023 A new accept SHALL NOT occur in the same cycle as the result handshake; minimum accept-to-accept period is WIDTH+2 cycles.
REQ-024 d, bout, ovf SHALL hold their last values in IDLE and RUN until overwritten; consumers SHALL qualify them with out_valid.
REQ-025 out_ready while not in DONE SHALL be ignored.
REQ-026 a = b SHALL yield d = 0, bout = 0, ovf = 0; b = 0 SHALL yield d = a, bout = 0, ovf = 0.

Reset
REQ-027 On any edge with rst_n=0 the block SHALL enter IDLE regardless of state, discarding any partial result.
REQ-028 Reset values: in_ready=1 after reset released (IDLE), out_valid=0, d=0, bout=0, ovf=0, counter=0, borrow=0.
REQ-029 rst_n=0 held with in_valid=1 SHALL NOT accept operands; first accept is on the first edge with rst_n=1.

Verification
REQ-030 Bench (WIDTH=8): a=10, b=5, out_ready=1 -> out_valid 8 edges after accept, d=0x05, bout=0, ovf=0.
REQ-031 a=5, b=10 -> d=0xFB, bout=1, ovf=0; a=0x80, b=0x01 -> d=0x7F, bout=0, ovf=1.
REQ-032 a=0x00, b=0xFF -> d=0x01, bout=1, ovf=0; a=0x7F, b=0x80 -> d=0xFF, bout=1, ovf=1.
REQ-033 Backpressure: a=0xC8, b=0x64, out_ready=0 for 5 cycles in DONE -> d=0x64, bout=0, ovf=1 stable all 5 cycles; in_ready=0 throughout; release -> IDLE next cycle.
REQ-034 Reset mid-RUN: accept a=0xFF, b=0x01, rst_n=0 at 4th RUN edge -> out_valid=0, d=0, in_ready=1 after release; next op a=3, b=1 -> d=0x02, bout=0.
REQ-035 Back-to-back: in_valid held 1 with a/b changed right after each accept -> each result matches operands at its accept edge; accepts spaced exactly 10 cycles with out_ready=1.
